// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the memory-wait FSM state encoding and the default register-address
// width used by the controller and its hazard detector.
package pipe_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detector for the ID stage.
// Ports:
//   id_valid, id_src1, id_src2, id_two_src   : ID stage instruction operands
//   exe_dest, exe_wb_en, exe_mem_read         : EXE stage producer
//   mem_dest, mem_wb_en                       : MEM stage producer
//   fwd_en                                    : forwarding unit enabled
//   hz                                        : stall-worthy hazard present
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  fwd_en,
    output logic                  hz
);

    logic match1;
    logic match2;
    logic load_use1;
    logic load_use2;
    logic hz_nofwd;
    logic hz_fwd;

    assign match1    = (exe_wb_en && (id_src1 == exe_dest)) || (mem_wb_en && (id_src1 == mem_dest));
    assign match2    = (exe_wb_en && (id_src2 == exe_dest)) || (mem_wb_en && (id_src2 == mem_dest));
    assign load_use1 = (id_src1 == exe_dest);
    assign load_use2 = (id_src2 == exe_dest);

    assign hz_nofwd = match1 || (id_two_src && match2);
    // With forwarding, only a load in EXE cannot be bypassed in time.
    assign hz_fwd   = exe_mem_read && exe_wb_en && (load_use1 || (id_two_src && load_use2));

    assign hz = id_valid && (fwd_en ? hz_fwd : hz_nofwd);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, rst (async, active-low)
//   id_*, exe_*, mem_*, fwd_en  : hazard detection inputs
//   exe_branch                  : taken branch resolved in EXE
//   mem_req, mem_ready          : data memory handshake
//   perf_clr                    : synchronous clear of stall_cycles
//   freeze_if/id/exe/mem        : stage register holds
//   flush_if_id, flush_id_exe   : stage register clears
//   mem_timeout                 : sticky memory watchdog fault
//   stall_cycles                : saturating count of freeze_if cycles
//
// state    | meaning
// RUN      | normal flow, no outstanding memory wait
// MEM_WAIT | memory access stalled, watchdog counting
// FAULT    | watchdog expired; pipeline frozen until reset
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  fwd_en,
    input  logic                  exe_branch,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  perf_clr,
    output logic                  freeze_if,
    output logic                  freeze_id,
    output logic                  freeze_exe,
    output logic                  freeze_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_exe,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0]    WAIT_LAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] wait_cnt;
    logic [TW-1:0] wait_cnt_nxt;
    logic          hz;
    logic          mem_stall;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .fwd_en       (fwd_en),
        .hz           (hz)
    );

    assign mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                wait_cnt_nxt = '0;
                if (mem_stall) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Count parks at its last value if mem_req drops without ready.
                    if (mem_stall) state_nxt = FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + TW'(1);
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs are gated by rst so they fall the moment reset asserts,
    // even while the combinational hazard/memory inputs are still active.
    always_comb begin
        freeze_if    = 1'b0;
        freeze_id    = 1'b0;
        freeze_exe   = 1'b0;
        freeze_mem   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        if (!rst) begin
            freeze_if = 1'b0;
        end else if ((state == FAULT) || mem_stall) begin
            freeze_if  = 1'b1;
            freeze_id  = 1'b1;
            freeze_exe = 1'b1;
            freeze_mem = 1'b1;
        end else if (exe_branch) begin
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
        end else if (hz) begin
            freeze_if    = 1'b1;
            flush_id_exe = 1'b1;
        end
    end

    assign mem_timeout = rst && (state == FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (freeze_if && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    localparam int RW      = 4;
    localparam int TMO     = 4;
    localparam int CW      = 4;
    localparam int CNT_TOP = (1 << CW) - 1;

    typedef struct packed {
        logic          rst;
        logic          id_valid;
        logic [RW-1:0] id_src1;
        logic [RW-1:0] id_src2;
        logic          id_two_src;
        logic [RW-1:0] exe_dest;
        logic          exe_wb_en;
        logic          exe_mem_read;
        logic [RW-1:0] mem_dest;
        logic          mem_wb_en;
        logic          fwd_en;
        logic          exe_branch;
        logic          mem_req;
        logic          mem_ready;
        logic          perf_clr;
    } stim_t;

    typedef struct packed {
        logic          fi;
        logic          fid;
        logic          fexe;
        logic          fmem;
        logic          fl_if;
        logic          fl_id;
        logic          tmo;
        logic [CW-1:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_two_src = 1'b0, exe_wb_en = 1'b0, exe_mem_read = 1'b0;
    logic mem_wb_en = 1'b0, fwd_en = 1'b0, exe_branch = 1'b0, mem_req = 1'b0;
    logic mem_ready = 1'b0, perf_clr = 1'b0;
    logic [RW-1:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, flush_id_exe, mem_timeout;
    logic [CW-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    // Reference model state: in_wait/wait_n track consecutive memory-wait
    // cycles, in_fault is the sticky watchdog, perf is the saturating counter.
    bit in_wait  = 0;
    int wait_n   = 0;
    bit in_fault = 0;
    int perf     = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_ADDR_W  (RW),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .fwd_en       (fwd_en),
        .exe_branch   (exe_branch),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .perf_clr     (perf_clr),
        .freeze_if    (freeze_if),
        .freeze_id    (freeze_id),
        .freeze_exe   (freeze_exe),
        .freeze_mem   (freeze_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_exe (flush_id_exe),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    function automatic bit writes(input stim_t s, input logic [RW-1:0] r);
        return (s.exe_wb_en && r == s.exe_dest) || (s.mem_wb_en && r == s.mem_dest);
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        bit   hzd;
        bit   hold;
        e = '0;
        if (!s.rst) return e;
        if (!s.id_valid)
            hzd = 0;
        else if (!s.fwd_en)
            hzd = writes(s, s.id_src1) || (s.id_two_src && writes(s, s.id_src2));
        else
            hzd = s.exe_mem_read && s.exe_wb_en &&
                  (s.id_src1 == s.exe_dest || (s.id_two_src && s.id_src2 == s.exe_dest));
        hold = in_fault || (s.mem_req && !s.mem_ready);
        if (hold) begin
            e.fi = 1; e.fid = 1; e.fexe = 1; e.fmem = 1;
        end else if (s.exe_branch) begin
            e.fl_if = 1; e.fl_id = 1;
        end else if (hzd) begin
            e.fi = 1; e.fl_id = 1;
        end
        e.tmo = in_fault;
        e.sc  = CW'(perf);
        return e;
    endfunction

    task automatic model_advance(input stim_t s, input exp_t e);
        bit stalled;
        stalled = s.mem_req && !s.mem_ready;
        if (!s.rst) begin
            in_wait = 0; wait_n = 0; in_fault = 0; perf = 0;
            return;
        end
        if (s.perf_clr) perf = 0;
        else if (e.fi) perf = (perf < CNT_TOP) ? perf + 1 : CNT_TOP;
        if (in_fault) begin
            // sticky
        end else if (in_wait) begin
            if (s.mem_ready) begin
                in_wait = 0; wait_n = 0;
            end else if (wait_n + 1 >= TMO) begin
                // this was the TMO-th consecutive wait cycle
                if (stalled) begin in_fault = 1; in_wait = 0; end
            end else begin
                wait_n = wait_n + 1;
            end
        end else if (stalled) begin
            in_wait = 1; wait_n = 0;
        end
    endtask

    task automatic drive(input stim_t s);
        rst          = s.rst;
        id_valid     = s.id_valid;
        id_src1      = s.id_src1;
        id_src2      = s.id_src2;
        id_two_src   = s.id_two_src;
        exe_dest     = s.exe_dest;
        exe_wb_en    = s.exe_wb_en;
        exe_mem_read = s.exe_mem_read;
        mem_dest     = s.mem_dest;
        mem_wb_en    = s.mem_wb_en;
        fwd_en       = s.fwd_en;
        exe_branch   = s.exe_branch;
        mem_req      = s.mem_req;
        mem_ready    = s.mem_ready;
        perf_clr     = s.perf_clr;
    endtask

    task automatic step(input stim_t s, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        drive(s);
        e = model_out(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        model_advance(s, e);
    endtask

    // Monitor: compares every cycle the stimulus has queued an expectation.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  got;
        string t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {freeze_if, freeze_id, freeze_exe, freeze_mem,
                   flush_if_id, flush_id_exe, mem_timeout, stall_cycles};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got fz(if,id,exe,mem)=%b%b%b%b fl=%b%b tmo=%b sc=%0d, want fz=%b%b%b%b fl=%b%b tmo=%b sc=%0d",
                         t, got.fi, got.fid, got.fexe, got.fmem, got.fl_if, got.fl_id, got.tmo, got.sc,
                         e.fi, e.fid, e.fexe, e.fmem, e.fl_if, e.fl_id, e.tmo, e.sc);
            end
        end
    end

    initial begin
        stim_t s;
        stim_t b;
        int    drain;

        s = '0;
        step(s, "reset");
        step(s, "reset2");

        // T1: no-forwarding RAW on src1, then forwarding with no load
        b = '0; b.rst = 1;
        step(b, "idle");
        s = b; s.id_valid = 1; s.id_src1 = 3; s.exe_dest = 3; s.exe_wb_en = 1;
        step(s, "t1_raw");
        s.fwd_en = 1;
        step(s, "t1_fwd_noload");
        s.fwd_en = 0; s.exe_wb_en = 0; s.mem_wb_en = 1; s.mem_dest = 3;
        step(s, "t1_raw_mem");
        s.id_valid = 0;
        step(s, "t1_invalid");

        // T2: load-use via src2, then src2 not live
        s = b; s.id_valid = 1; s.fwd_en = 1; s.exe_mem_read = 1; s.exe_wb_en = 1;
        s.exe_dest = 5; s.id_two_src = 1; s.id_src2 = 5; s.id_src1 = 1;
        step(s, "t2_loaduse");
        s.id_two_src = 0;
        step(s, "t2_src2_dead");

        // T3: branch overrides hazard
        s = b; s.id_valid = 1; s.id_src1 = 3; s.exe_dest = 3; s.exe_wb_en = 1; s.exe_branch = 1;
        step(s, "t3_branch");

        // T4: three memory stall cycles with a branch held, then release
        s = b; s.perf_clr = 1;
        step(s, "t4_clr");
        s = b; s.mem_req = 1; s.exe_branch = 1;
        for (int i = 0; i < 3; i++) step(s, "t4_stall");
        s.mem_ready = 1;
        step(s, "t4_release");
        step(b, "t4_count");

        // T5: watchdog expiry, sticky fault, async reset back to RUN
        s = b; s.mem_req = 1;
        for (int i = 0; i < 7; i++) step(s, "t5_wait");
        s.mem_req = 0;
        step(s, "t5_fault_held");
        s.rst = 0; s.mem_req = 1;
        step(s, "t5_rst");
        step(b, "t5_run");
        s = b; s.mem_req = 1; s.mem_ready = 1;
        step(s, "t5_ready_same_cycle");
        step(b, "t5_after_ready");

        // T6: saturation then clear while stalled
        s = b; s.id_valid = 1; s.id_src1 = 7; s.exe_dest = 7; s.exe_wb_en = 1;
        for (int i = 0; i < CNT_TOP + 4; i++) step(s, "t6_sat");
        s.perf_clr = 1;
        step(s, "t6_clr");
        step(b, "t6_zero");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.rst          = ($urandom_range(0, 79) != 0);
            s.id_valid     = ($urandom_range(0, 3) != 0);
            s.id_src1      = RW'($urandom_range(0, 3));
            s.id_src2      = RW'($urandom_range(0, 3));
            s.id_two_src   = 1'($urandom_range(0, 1));
            s.exe_dest     = RW'($urandom_range(0, 3));
            s.exe_wb_en    = 1'($urandom_range(0, 1));
            s.exe_mem_read = 1'($urandom_range(0, 1));
            s.mem_dest     = RW'($urandom_range(0, 3));
            s.mem_wb_en    = 1'($urandom_range(0, 1));
            s.fwd_en       = 1'($urandom_range(0, 1));
            s.exe_branch   = ($urandom_range(0, 4) == 0);
            s.mem_req      = ($urandom_range(0, 2) == 0);
            s.mem_ready    = ($urandom_range(0, 2) != 0);
            s.perf_clr     = ($urandom_range(0, 29) == 0);
            step(s, "random");
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
